cmac_tx_packet_buffer: RTL and testbench
========================================

Name: cmac_tx_packet_buffer

Overview:
- Store-and-forward packet FIFO between the UDP engine CMAC TX output and the CMAC TX AXI-Stream input.
- The CMAC underflows if tvalid drops mid-frame. This block releases a frame to the CMAC only after its last beat has been fully stored, so the frame then streams without gaps.
- Frames longer than a configured beat limit are discarded.
- Single clock domain: tx_axis_aclk.

Parameters:
- DATA_WIDTH, 512, stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- DEPTH, 64, buffer depth in beats; power of 2, minimum 4.
- MAX_PKT_BEATS, 24, largest accepted frame in beats; must be ≤ DEPTH; longer frames are dropped.
- CNT_WIDTH, $clog2(DEPTH)+1, width of occupancy and packet-count outputs.

Ports:
- tx_axis_aclk  in  1  clock.
- tx_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  frame data from engine.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  data to CMAC.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables to CMAC.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  output last beat.
- m_axis_tready  in  1  CMAC ready.
- buf_level  out  CNT_WIDTH  beats held, committed plus in-progress.
- buf_pkt_count  out  CNT_WIDTH  committed frames not yet fully sent.
- drop_pulse  out  1  one-cycle pulse when an oversize frame's tlast is consumed.
- stat_pkt_total  out  32  frames sent; optional.
- stat_drop_total  out  32  frames dropped; optional.

Behaviour:
- Reset (asynchronous): all pointers, counters and status outputs go to 0. m_axis_tvalid, m_axis_tlast and drop_pulse are 0. s_axis_tready is 0 while tx_axis_aresetn is low. Data outputs are don't-care. A partial frame held at reset is lost. Read-state reset value is IDLE; write-state reset value is ACCEPT.
- Write side, pointers:
  - Committed pointer wr_ptr and tentative pointer wr_tmp; the memory is written at wr_tmp.
  - An input beat transfers when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = (wr_tmp − rd_ptr) != DEPTH in ACCEPT state; it is forced to 1 in DROP state.
- Write side, states:
  - ACCEPT: each transferred beat is written and a frame beat counter increments.
  - On a tlast transfer: wr_ptr ← wr_tmp+1, buf_pkt_count increments, beat counter clears.
  - If a non-tlast beat would be beat number MAX_PKT_BEATS+1: rewind wr_tmp ← wr_ptr and move to DROP. That beat is not written.
  - DROP: tready stays 1 and beats are discarded. On a tlast transfer, drop_pulse=1 for one cycle, then return to ACCEPT.
  - A frame of exactly MAX_PKT_BEATS beats is accepted.
- Backpressure: a full buffer stalls the input and never drops. No deadlock is possible, because an in-progress frame is at most MAX_PKT_BEATS ≤ DEPTH beats.
- Read side, states IDLE → SEND → IDLE:
  - Leave IDLE when buf_pkt_count>0.
  - In SEND, m_axis_tvalid stays 1 on every cycle until the beat with tlast is accepted.
  - On acceptance of the tlast beat, buf_pkt_count decrements.
  - A new frame may start on the cycle after a tlast transfer: back-to-back output is allowed with no bubble.
- Output register: the output is registered with a 2-entry skid so m_axis_tready low never loses data; output beats are held stable while stalled.
- Latency: with the buffer empty and m_axis_tready=1, an input tlast accepted at cycle N puts the first beat of that frame on m_axis at cycle N+2.
- Simultaneous input commit and output tlast in the same cycle: buf_pkt_count is unchanged; buf_level is updated by net beats.
- Pointers are CNT_WIDTH wide and wrap modulo 2·DEPTH; full/empty are decided by pointer difference.
- tkeep passes through unchanged.

Optional Feature:
- Macro CMAC_TX_PKT_BUF_STATS_EN.
- Defined: stat_pkt_total increments on each output tlast transfer; stat_drop_total increments with each drop_pulse. Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- Single 3-beat frame, m_axis_tready=1 → identical 3 beats out; first output beat at input-tlast cycle + 2; buf_pkt_count goes 0→1→0.
- Ten 1-beat frames back-to-back with m_axis_tready=1 → ten output beats, tlast on each, no idle cycles after the first.
- 25-beat frame with MAX_PKT_BEATS=24, followed by a 2-beat frame → only the 2-beat frame emitted; drop_pulse once; stat_drop_total=1 with the macro.
- m_axis_tready held 0, 70 beats offered as frames of 8 beats, DEPTH=64 → s_axis_tready falls at buf_level=64; after release, all beats emerge in order with tvalid continuous inside each frame.
- Random m_axis_tready toggling over 200 frames → output data matches a scoreboard and tvalid never drops between first and last beat of a frame.
- Reset asserted mid-frame on both sides → all outputs 0 immediately; after release, a new 2-beat frame passes correctly.

Source files
------------

// File: rtl/cmac_tx_packet_buffer.sv
// cmac_tx_packet_buffer: store-and-forward TX frame FIFO with oversize drop; CMAC_TX_PKT_BUF_STATS_EN adds frame/drop totals
module cmac_tx_packet_buffer #(
   parameter int DATA_WIDTH    = 512,
   parameter int KEEP_WIDTH    = DATA_WIDTH/8,
   parameter int DEPTH         = 64,
   parameter int MAX_PKT_BEATS = 24,
   parameter int CNT_WIDTH     = $clog2(DEPTH)+1
) (
   input  logic                  tx_axis_aclk,
   input  logic                  tx_axis_aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [CNT_WIDTH-1:0]  buf_level,
   output logic [CNT_WIDTH-1:0]  buf_pkt_count,
   output logic                  drop_pulse,
   output logic [31:0]           stat_pkt_total,
   output logic [31:0]           stat_drop_total
);
   localparam int AW = $clog2(DEPTH);
   localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam int BW = $clog2(MAX_PKT_BEATS+1);
   typedef enum logic {ACCEPT, DROP} wstate_t;
   typedef enum logic {IDLE, SEND} rstate_t;
   logic [MW-1:0] mem [DEPTH];
   logic [MW-1:0] rd_word, out0, out1;
   logic [CNT_WIDTH-1:0] wr_ptr, wr_tmp, rd_ptr, rd_pkts, pkt_cnt;
   logic [BW-1:0] beat_cnt;
   logic [1:0] oc;
   wstate_t wstate, wstate_nx;
   rstate_t rstate, rstate_nx;
   logic in_xfer, over, wr_en, commit, drop_now, rd_en, rd_last, out_xfer, out_done;
   assign in_xfer  = s_axis_tvalid && s_axis_tready;
   assign over     = wstate == ACCEPT && beat_cnt == BW'(MAX_PKT_BEATS);
   assign wr_en    = in_xfer && wstate == ACCEPT && !over;
   assign commit   = wr_en && s_axis_tlast;
   assign drop_now = in_xfer && s_axis_tlast && (wstate == DROP || over);
   assign rd_word  = mem[rd_ptr[AW-1:0]];
   assign rd_last  = rd_word[MW-1];
   assign out_xfer = m_axis_tvalid && m_axis_tready;
   assign out_done = out_xfer && m_axis_tlast;
   // write state register
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn)
      if (!tx_axis_aresetn) wstate <= ACCEPT;
      else wstate <= wstate_nx;
   // an over-limit non-last beat discards the rest of the frame
   always_comb
      wstate_nx = (over && in_xfer && !s_axis_tlast) ? DROP :
                  (wstate == DROP && in_xfer && s_axis_tlast) ? ACCEPT : wstate;
   // over-limit beats are always taken so a full buffer of one oversize frame cannot lock up
   always_comb
      s_axis_tready = tx_axis_aresetn && (wstate == DROP || over || (wr_tmp - rd_ptr) != CNT_WIDTH'(DEPTH));
   // tentative/committed write pointers, frame beat count, drop pulse
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn)
      if (!tx_axis_aresetn) begin
         wr_ptr     <= '0;
         wr_tmp     <= '0;
         beat_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop_now;
         if (wr_en) begin
            wr_tmp   <= wr_tmp + 1'b1;
            beat_cnt <= s_axis_tlast ? '0 : beat_cnt + 1'b1;
            if (s_axis_tlast) wr_ptr <= wr_tmp + 1'b1;
         end else if (in_xfer && over) begin
            wr_tmp   <= wr_ptr;
            beat_cnt <= '0;
         end
      end
   // frame storage, tlast kept alongside each beat
   always_ff @(posedge tx_axis_aclk)
      if (wr_en) mem[wr_tmp[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   // read state register
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn)
      if (!tx_axis_aresetn) rstate <= IDLE;
      else rstate <= rstate_nx;
   // a tlast read returns to IDLE, which may immediately start the next frame
   always_comb
      rstate_nx = rd_en ? (rd_last ? IDLE : SEND) : rstate;
   // read into the skid whenever it has a free slot and a committed frame is pending
   always_comb
      rd_en = (rstate == SEND || rd_pkts != '0) && oc != 2'd2;
   // read pointer, unread-frame count, unsent-frame count, skid occupancy
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn)
      if (!tx_axis_aresetn) begin
         rd_ptr  <= '0;
         rd_pkts <= '0;
         pkt_cnt <= '0;
         oc      <= '0;
      end else begin
         rd_ptr  <= rd_ptr + CNT_WIDTH'(rd_en);
         rd_pkts <= rd_pkts + CNT_WIDTH'(commit) - CNT_WIDTH'(rd_en && rd_last);
         pkt_cnt <= pkt_cnt + CNT_WIDTH'(commit) - CNT_WIDTH'(out_done);
         oc      <= oc + 2'(rd_en) - 2'(out_xfer);
      end
   // two-entry output skid: out0 drives m_axis, out1 catches the beat read while stalled
   always_ff @(posedge tx_axis_aclk) begin
      if ((rd_en && (oc == 2'd0 || (oc == 2'd1 && out_xfer))) || (out_xfer && oc == 2'd2))
         out0 <= (oc == 2'd2) ? out1 : rd_word;
      if (rd_en && oc == 2'd1 && !out_xfer) out1 <= rd_word;
   end
   assign m_axis_tvalid = oc != 2'd0;
   assign m_axis_tlast  = m_axis_tvalid && out0[MW-1];
   assign m_axis_tkeep  = out0[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis_tdata  = out0[DATA_WIDTH-1:0];
   assign buf_level     = wr_tmp - rd_ptr;
   assign buf_pkt_count = pkt_cnt;
`ifdef CMAC_TX_PKT_BUF_STATS_EN
   // saturating frame-sent and frame-dropped totals
   always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn)
      if (!tx_axis_aresetn) begin
         stat_pkt_total  <= '0;
         stat_drop_total <= '0;
      end else begin
         if (out_done && stat_pkt_total != '1) stat_pkt_total <= stat_pkt_total + 1'b1;
         if (drop_pulse && stat_drop_total != '1) stat_drop_total <= stat_drop_total + 1'b1;
      end
`else
   assign stat_pkt_total  = '0;
   assign stat_drop_total = '0;
`endif
endmodule

// File: tb/tb_cmac_tx_packet_buffer.sv
// tb_cmac_tx_packet_buffer: random frames against a queue scoreboard of accepted beats
module tb_cmac_tx_packet_buffer;
   localparam int DW = 64, KW = 8, DEPTH = 64, MAXB = 24, CW = 7;
   logic clk = 0, rst_n = 0;
   logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
   logic [KW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
   logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
   logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1, drop_pulse;
   logic [CW-1:0] buf_level, buf_pkt_count;
   logic [31:0] stat_pkt_total, stat_drop_total;
   always #5 clk = ~clk;
   cmac_tx_packet_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB)) dut (
      .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .buf_level(buf_level), .buf_pkt_count(buf_pkt_count), .drop_pulse(drop_pulse),
      .stat_pkt_total(stat_pkt_total), .stat_drop_total(stat_drop_total));
   int total = 0, bad = 0;
   task automatic check(string tag, logic [95:0] got, logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   logic [72:0] sb[$];
   int out_edges[$];
   int cyc = 0, drops_exp = 0, drops_seen = 0, sent_seen = 0, ok_frames = 0, extras = 0;
   int last_in_tlast = 0, first_out_edge = 0;
   bit in_frame = 0, fill_done = 0, rnd_done = 0;
   always @(posedge clk) cyc++;
   always @(negedge clk)
      if (rst_n) begin
         if (drop_pulse) drops_seen++;
         if (in_frame) check("tvalid_gap", m_axis_tvalid, 1);
         if (s_axis_tvalid && s_axis_tready && s_axis_tlast) last_in_tlast = cyc + 1;
         if (m_axis_tvalid && m_axis_tready) begin
            out_edges.push_back(cyc + 1);
            if (!in_frame) first_out_edge = cyc + 1;
            if (sb.size() == 0) extras++;
            else check("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, sb.pop_front());
            in_frame = !m_axis_tlast;
            if (m_axis_tlast) sent_seen++;
         end
      end
   task automatic send_frame(int len, bit gaps);
      if (len > MAXB) drops_exp++;
      else ok_frames++;
      for (int i = 0; i < len; i++) begin
         logic [72:0] b;
         int w;
         if (gaps)
            while ($urandom_range(0, 3) == 0) begin
               s_axis_tvalid = 0;
               @(posedge clk); #1;
            end
         b = {(i == len - 1), 8'($urandom), $urandom, $urandom};
         {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = b;
         s_axis_tvalid = 1;
         w = 0;
         while (!s_axis_tready) begin
            @(posedge clk); #1;
            if (++w > 20000) begin
               $display("FAIL in_ready_timeout got=0 exp=1");
               $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
               $fatal(1);
            end
         end
         @(posedge clk); #1;
         if (len <= MAXB) sb.push_back(b);
      end
      s_axis_tvalid = 0;
      s_axis_tlast = 0;
   endtask
   task automatic drain(string tag);
      int w = 0;
      m_axis_tready = 1;
      while ((sb.size() != 0 || m_axis_tvalid || buf_pkt_count != 0) && w < 5000) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_left"}, sb.size(), 0);
      check({tag, "_extra"}, extras, 0);
      check({tag, "_pkts"}, buf_pkt_count, 0);
      check({tag, "_level"}, buf_level, 0);
      check({tag, "_sent"}, sent_seen, ok_frames);
      check({tag, "_drops"}, drops_seen, drops_exp);
`ifdef CMAC_TX_PKT_BUF_STATS_EN
      check({tag, "_stat_pkt"}, stat_pkt_total, ok_frames);
      check({tag, "_stat_drop"}, stat_drop_total, drops_exp);
`else
      check({tag, "_stat_pkt"}, stat_pkt_total, 0);
      check({tag, "_stat_drop"}, stat_drop_total, 0);
`endif
   endtask
   task automatic check_reset(string tag);
      check({tag, "_tvalid"}, m_axis_tvalid, 0);
      check({tag, "_tlast"}, m_axis_tlast, 0);
      check({tag, "_s_ready"}, s_axis_tready, 0);
      check({tag, "_level"}, buf_level, 0);
      check({tag, "_pkts"}, buf_pkt_count, 0);
      check({tag, "_drop"}, drop_pulse, 0);
      check({tag, "_stats"}, {stat_pkt_total, stat_drop_total}, 0);
   endtask
   initial begin
      int w;
      #1 check_reset("rst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      check("idle_s_ready", s_axis_tready, 1);
      check("t1_pkts0", buf_pkt_count, 0);
      send_frame(3, 0);
      check("t1_pkts1", buf_pkt_count, 1);
      drain("t1");
      check("t1_latency", first_out_edge - last_in_tlast, 2);
      out_edges.delete();
      for (int i = 0; i < 10; i++) send_frame(1, 0);
      drain("t2");
      check("t2_count", out_edges.size(), 10);
      if (out_edges.size() == 10) check("t2_span", out_edges[9] - out_edges[0], 9);
      send_frame(MAXB + 1, 0);
      send_frame(2, 0);
      drain("t3");
      send_frame(MAXB, 0);
      drain("t3_max");
      m_axis_tready = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send_frame(8, 0);
            send_frame(6, 0);
            fill_done = 1;
         end
      join_none
      w = 0;
      while (s_axis_tready && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      check("t4_stalled", s_axis_tready, 0);
      check("t4_full_level", buf_level, DEPTH);
      repeat (5) @(posedge clk);
      #1 check("t4_still_stalled", s_axis_tready, 0);
      m_axis_tready = 1;
      w = 0;
      while (!fill_done && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      check("t4_fill_done", fill_done, 1);
      drain("t4");
      fork
         begin
            for (int i = 0; i < 200; i++) send_frame($urandom_range(1, MAXB + 2), 1);
            rnd_done = 1;
         end
         while (!rnd_done) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      join
      drain("t5");
      m_axis_tready = 0;
      send_frame(2, 0);
      for (int i = 0; i < 3; i++) begin
         {s_axis_tkeep, s_axis_tdata} = {8'($urandom), $urandom, $urandom};
         s_axis_tlast = 0;
         s_axis_tvalid = 1;
         @(posedge clk); #1;
      end
      check("t6_busy_tvalid", m_axis_tvalid, 1);
      #3 rst_n = 0;
      #1 check_reset("t6_rst");
      s_axis_tvalid = 0;
      sb.delete();
      in_frame = 0;
      {drops_exp, drops_seen, sent_seen, ok_frames} = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      m_axis_tready = 1;
      @(posedge clk); #1;
      send_frame(2, 0);
      drain("t6");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
